// File: rtl/half_band_fir_mac.sv
// Sample-serial 255-tap FIR: circular delay line, one-cycle-latency coefficient BROM,
// 40-bit multiply-accumulate, Q1.15 rescale with saturation to the output width.
module half_band_fir_mac #(
  parameter int NUM_TAPS  = 255,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15,
  parameter int ACC_W     = 40
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [7:0]        coef_address,
  output logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_data_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = 9;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_MAC, S_DRAIN, S_OUTPUT} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [7:0]               r_clrAddr;
  logic [7:0]               r_wrPtr;
  logic [7:0]               r_k;
  logic [CNT_W-1:0]         r_coefCnt;
  logic signed [DATA_W-1:0] r_sample;
  logic [DATA_W-1:0]        r_dout;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_delayLine [256];

  logic                     w_accept;
  logic                     w_lastTap;
  logic                     w_allCoefs;
  logic                     w_accumulate;
  logic                     w_memWe;
  logic [7:0]               w_memAddr;
  logic [7:0]               w_rdAddr;
  logic [DATA_W-1:0]        w_memData;
  logic signed [PROD_W-1:0] w_product;
  logic signed [ACC_W-1:0]  w_productExt;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [ACC_W-DATA_W:0]    w_hiBits;
  logic [DATA_W-1:0]        w_result;

  assign w_accept     = (r_state == S_IDLE) && din_valid;
  assign w_lastTap    = (r_k == 8'(NUM_TAPS - 1));
  assign w_allCoefs   = (r_coefCnt == CNT_W'(NUM_TAPS));
  assign w_accumulate = coef_data_valid && ((r_state == S_MAC) || (r_state == S_DRAIN));

  assign w_product    = $signed(coef_data) * r_sample;
  assign w_productExt = {{(ACC_W-PROD_W){w_product[PROD_W-1]}}, w_product};
  assign w_shifted    = r_acc >>> COEF_FRAC;
  // Result fits only when every bit above the output sign bit matches it.
  assign w_hiBits     = w_shifted[ACC_W-1:DATA_W-1];

  always_comb begin
    w_result = w_shifted[DATA_W-1:0];
    if (!((&w_hiBits) || !(|w_hiBits))) begin
      if (w_hiBits[ACC_W-DATA_W]) w_result = {1'b1, {(DATA_W-1){1'b0}}};
      else                        w_result = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  assign w_memWe   = reset_n && ((r_state == S_CLEAR) || w_accept);
  assign w_memAddr = (r_state == S_CLEAR) ? r_clrAddr : r_wrPtr;
  assign w_memData = (r_state == S_CLEAR) ? '0 : din;
  assign w_rdAddr  = r_wrPtr - r_k;

  // Read lands one cycle after the address is issued, lining up with the BROM reply.
  always_ff @(posedge clk) begin
    if (w_memWe) r_delayLine[w_memAddr] <= w_memData;
    r_sample <= r_delayLine[w_rdAddr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_CLEAR;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    din_ready   = 1'b0;
    coef_valid  = 1'b0;
    dout_valid  = 1'b0;
    case (r_state)
      S_CLEAR:  if (r_clrAddr == 8'd255) w_nextState = S_IDLE;
      S_IDLE: begin
        din_ready = 1'b1;
        if (din_valid) w_nextState = S_MAC;
      end
      S_MAC: begin
        coef_valid = 1'b1;
        if (w_lastTap) w_nextState = S_DRAIN;
      end
      S_DRAIN:  if (w_allCoefs) w_nextState = S_OUTPUT;
      S_OUTPUT: begin
        dout_valid = 1'b1;
        if (dout_ready) w_nextState = S_IDLE;
      end
      default:  w_nextState = S_CLEAR;
    endcase
  end

  // The coefficient count tells DRAIN when the last product has been folded in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_clrAddr <= '0;
      r_wrPtr   <= '0;
      r_k       <= '0;
      r_coefCnt <= '0;
      r_acc     <= '0;
      r_dout    <= '0;
    end else begin
      case (r_state)
        S_CLEAR:  r_clrAddr <= r_clrAddr + 8'd1;
        S_IDLE: begin
          if (din_valid) begin
            r_acc     <= '0;
            r_k       <= '0;
            r_coefCnt <= '0;
          end
        end
        S_MAC:    r_k <= w_lastTap ? 8'd0 : r_k + 8'd1;
        S_DRAIN:  if (w_allCoefs) r_dout <= w_result;
        S_OUTPUT: if (dout_ready) r_wrPtr <= r_wrPtr + 8'd1;
        default:  ;
      endcase
      if (w_accumulate) begin
        r_acc     <= r_acc + w_productExt;
        r_coefCnt <= r_coefCnt + CNT_W'(1);
      end
    end
  end

  assign coef_address = r_k;
  assign dout         = r_dout;

endmodule

// File: tb/tb_half_band_fir_mac.sv
// Directed bench for half_band_fir_mac: clear timing, address/latency, backpressure,
// impulse response, saturation and mid-operation reset against hand values and a golden model.
module tb_half_band_fir_mac;

  typedef struct {
    logic signed [15:0] din;
    logic signed [15:0] expected;
  } vector_t;

  typedef struct {
    int                 idx;
    logic signed [15:0] expected;
  } keyOut_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [15:0] din;
  logic               din_valid;
  logic               din_ready;
  logic [7:0]         coef_address;
  logic               coef_valid;
  logic signed [15:0] coef_data = '0;
  logic               coef_data_valid = 1'b0;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready;

  logic signed [15:0] coefRom [0:255];
  logic signed [15:0] hist [0:254];
  logic signed [15:0] impulseOut [0:255];
  logic signed [15:0] observed;
  logic signed [15:0] expectedOut;
  vector_t            satTable [6];
  vector_t            postResetTable [4];
  keyOut_t            impulseKeys [5];

  int checks = 0;
  int failures = 0;

  half_band_fir_mac dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .din             (din),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .coef_address    (coef_address),
    .coef_valid      (coef_valid),
    .coef_data       (coef_data),
    .coef_data_valid (coef_data_valid),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready)
  );

  always #5 clk = ~clk;

  // Coefficient BROM: one-cycle read latency with a matching valid.
  always @(posedge clk) begin
    coef_data_valid <= coef_valid;
    coef_data       <= coefRom[coef_address];
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic clearHistory();
    for (int k = 0; k < 255; k++) hist[k] = '0;
  endtask

  task automatic pushHistory(input logic signed [15:0] x);
    for (int k = 254; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endtask

  function automatic logic signed [15:0] goldenOutput();
    longint acc = 0;
    for (int k = 0; k < 255; k++) acc += longint'(coefRom[k]) * longint'(hist[k]);
    acc = acc >>> 15;
    if (acc > 64'sd32767)       acc = 32767;
    else if (acc < -64'sd32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic waitReady(output int cycles, output int validSeen);
    cycles = 0;
    validSeen = 0;
    while (!din_ready && cycles < 1000) begin
      if (dout_valid) validSeen++;
      cycles++;
      @(negedge clk);
    end
  endtask

  // One full sample transaction with dout_ready held high; entered and left on a negedge.
  task automatic applyStimulus(input logic signed [15:0] value, input logic signed [15:0] expected,
                               input string name, output logic signed [15:0] result);
    int waitCycles;
    int latency;
    din = value;
    din_valid = 1'b1;
    waitCycles = 0;
    while (!din_ready && waitCycles < 600) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({name, " accepted"}, din_ready, 1);
    @(negedge clk);
    din_valid = 1'b0;
    din = '0;
    latency = 1;
    while (!dout_valid && latency < 600) begin
      @(negedge clk);
      latency++;
    end
    checkOutput({name, " latency"}, latency, 258);
    checkOutput({name, " dout"}, dout, expected);
    result = dout;
    @(negedge clk);
    checkOutput({name, " din_ready after handshake"}, din_ready, 1);
  endtask

  initial begin
    int cnt;
    int seen;

    for (int k = 0; k < 256; k++) coefRom[k] = 16'(((k * 73) % 200) - 100);
    coefRom[0] = 16'sd25;
    coefRom[1] = -16'sd53;
    coefRom[2] = -16'sd25;
    for (int k = 3; k <= 10; k++) coefRom[k] = 16'sd20000;
    coefRom[127] = 16'sd16113;
    coefRom[255] = 16'sh7FFF;

    impulseKeys = '{'{0, 16'sd12}, '{1, -16'sd27}, '{2, -16'sd13}, '{127, 16'sd8056}, '{255, 16'sd0}};
    satTable = '{'{16'sd32767, 16'sd24}, '{16'sd32767, -16'sd28}, '{16'sd32767, -16'sd53},
                 '{16'sd32767, 16'sd19946}, '{16'sd32767, 16'sd32767}, '{16'sd32767, 16'sd32767}};
    postResetTable = '{'{16'sd16384, 16'sd12}, '{16'sd0, -16'sd27}, '{16'sd0, -16'sd13},
                       '{16'sd0, 16'sd10000}};

    reset_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset din_ready", din_ready, 0);
    checkOutput("reset coef_valid", coef_valid, 0);
    checkOutput("reset coef_address", coef_address, 0);
    checkOutput("reset dout_valid", dout_valid, 0);
    checkOutput("reset dout", dout, 0);

    reset_n = 1'b1;
    din = 16'sd16384;
    din_valid = 1'b1;
    waitReady(cnt, seen);
    checkOutput("clear cycles before din_ready", cnt, 256);
    checkOutput("dout_valid during clear", seen, 0);

    // First impulse sample: address sequence, latency and backpressure.
    clearHistory();
    pushHistory(16'sd16384);
    expectedOut = goldenOutput();
    @(negedge clk);
    din_valid = 1'b0;
    din = '0;
    for (int cyc = 1; cyc <= 257; cyc++) begin
      if (cyc <= 255)
        checkOutput($sformatf("coef addr cycle %0d", cyc), {coef_valid, coef_address}, {1'b1, 8'(cyc - 1)});
      else
        checkOutput($sformatf("coef_valid low cycle %0d", cyc), coef_valid, 0);
      checkOutput($sformatf("early dout_valid cycle %0d", cyc), dout_valid, 0);
      @(negedge clk);
    end
    checkOutput("dout_valid cycle 258", dout_valid, 1);
    for (int i = 0; i < 50; i++) begin
      checkOutput($sformatf("backpressure dout %0d", i), dout, expectedOut);
      checkOutput($sformatf("backpressure dout_valid %0d", i), dout_valid, 1);
      checkOutput($sformatf("backpressure din_ready %0d", i), din_ready, 0);
      if (i < 49) @(negedge clk);
    end
    impulseOut[0] = dout;
    dout_ready = 1'b1;
    @(negedge clk);
    checkOutput("din_ready after release", din_ready, 1);
    checkOutput("dout_valid after release", dout_valid, 0);

    for (int i = 1; i < 256; i++) begin
      pushHistory(16'sd0);
      applyStimulus(16'sd0, goldenOutput(), $sformatf("impulse %0d", i), observed);
      impulseOut[i] = observed;
    end
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("impulse key tap %0d", impulseKeys[i].idx),
                  impulseOut[impulseKeys[i].idx], impulseKeys[i].expected);

    for (int i = 0; i < 6; i++) begin
      pushHistory(satTable[i].din);
      applyStimulus(satTable[i].din, satTable[i].expected, $sformatf("sat table %0d", i), observed);
    end
    for (int i = 0; i < 18; i++) begin
      din = (i < 2) ? 16'sd32767 : -16'sd32768;
      pushHistory(din);
      applyStimulus(din, goldenOutput(), $sformatf("sat model %0d", i), observed);
    end

    // Reset while the MAC is at tap 100.
    din = 16'sd1000;
    din_valid = 1'b1;
    waitReady(cnt, seen);
    @(negedge clk);
    din_valid = 1'b0;
    cnt = 0;
    while (!(coef_valid && coef_address == 8'd100) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("cycles to tap 100", cnt, 100);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("mid reset coef_valid", coef_valid, 0);
    checkOutput("mid reset coef_address", coef_address, 0);
    checkOutput("mid reset din_ready", din_ready, 0);
    checkOutput("mid reset dout_valid", dout_valid, 0);
    checkOutput("mid reset dout", dout, 0);
    reset_n = 1'b1;
    din = 16'sd16384;
    din_valid = 1'b1;
    waitReady(cnt, seen);
    checkOutput("reclear cycles before din_ready", cnt, 256);
    checkOutput("dout_valid after mid reset", seen, 0);

    clearHistory();
    for (int i = 0; i < 4; i++)
      applyStimulus(postResetTable[i].din, postResetTable[i].expected,
                    $sformatf("post reset impulse %0d", i), observed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
